// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point adder front end: word widths,
// status flag bit positions and the requester FSM state encoding.
package fp_pkg;

    // Default IEEE-754 single-precision geometry.
    localparam int MANT_SIZE = 23;
    localparam int EXP_SIZE  = 8;
    localparam int WORD_W    = MANT_SIZE + EXP_SIZE + 1;

    // Status flags returned with every response: {NAN, overflow, underflow, zero}.
    localparam int FLAG_W    = 4;
    localparam int FLAG_NAN  = 3;
    localparam int FLAG_OVF  = 2;
    localparam int FLAG_UNF  = 1;
    localparam int FLAG_ZERO = 0;

    // Requester sequencing: accept, strobe the adder, wait for done, hand back.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } fsm_state_t;

    // Full word width (sign + exponent + mantissa) for a given geometry.
    function automatic int word_width(input int mant, input int expo);
        return mant + expo + 1;
    endfunction

endpackage

// File: rtl/fp_add_requester_if.sv
// Bundle of the request channel, response channel and adder-side signals of
// the floating-point adder front end. The master modport is the requester
// itself (it masters the adder and serves the request/response channels);
// the slave modport is everything around it (command decoder + adder).
interface fp_add_requester_if
    import fp_pkg::*;
#(
    parameter int Mantissa_Size = MANT_SIZE,
    parameter int Exponent_Size = EXP_SIZE
);
    localparam int W = word_width(Mantissa_Size, Exponent_Size);

    // Request channel
    logic              req_valid;
    logic              req_ready;
    logic [W-1:0]      req_a;
    logic [W-1:0]      req_b;
    logic              req_sub;

    // Response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_result;
    logic [FLAG_W-1:0] rsp_flags;
    logic              rsp_timeout;

    // Adder side
    logic              add_enable;
    logic              add_load;
    logic [W-1:0]      add_A;
    logic [W-1:0]      add_B;
    logic [W-1:0]      add_result;
    logic              add_done;
    logic              add_zero_flag;
    logic              add_overflow;
    logic              add_underflow;
    logic              add_NAN;

    modport master (
        input  req_valid, req_a, req_b, req_sub,
        output req_ready,
        output rsp_valid, rsp_result, rsp_flags, rsp_timeout,
        input  rsp_ready,
        output add_enable, add_load, add_A, add_B,
        input  add_result, add_done, add_zero_flag, add_overflow, add_underflow, add_NAN
    );

    modport slave (
        output req_valid, req_a, req_b, req_sub,
        input  req_ready,
        input  rsp_valid, rsp_result, rsp_flags, rsp_timeout,
        output rsp_ready,
        input  add_enable, add_load, add_A, add_B,
        output add_result, add_done, add_zero_flag, add_overflow, add_underflow, add_NAN
    );

endinterface

// File: rtl/fp_add_requester.sv
// Initiator-side front end for the floating-point adder. Takes one operand
// pair at a time, turns subtraction into addition by flipping B's sign,
// strobes the adder, waits for done (bounded by TIMEOUT) and returns the
// result with its status flags. No request buffering: a new request is only
// taken once the previous response has been consumed.
// TIMEOUT must be at least 4 so that the wait window spans a valid done.
module fp_add_requester
    import fp_pkg::*;
#(
    parameter int Mantissa_Size = MANT_SIZE,
    parameter int Exponent_Size = EXP_SIZE,
    parameter int TIMEOUT       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    fp_add_requester_if.master bus
);

    localparam int W     = word_width(Mantissa_Size, Exponent_Size);
    localparam int CNT_W = $clog2(TIMEOUT);
    // Last WAIT cycle before the request is abandoned.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fsm_state_t        r_state;
    fsm_state_t        w_next_state;
    logic              r_active;
    logic [W-1:0]      r_add_a;
    logic [W-1:0]      r_add_b;
    logic [W-1:0]      r_rsp_result;
    logic [FLAG_W-1:0] r_rsp_flags;
    logic              r_rsp_timeout;
    logic [CNT_W-1:0]  r_wait_cnt;

    logic              w_accept;
    logic              w_done_ok;
    logic              w_timeout_hit;
    logic [W-1:0]      w_b_eff;
    logic [FLAG_W-1:0] w_adder_flags;

    // A request is taken only in IDLE, and only once we are out of reset.
    assign w_accept = (r_state == ST_IDLE) && r_active && bus.req_valid;

    // done is trusted only from the second WAIT cycle on: in the first one it
    // may still be the level left over from the previous operation.
    assign w_done_ok = (r_state == ST_WAIT) && bus.add_done && (r_wait_cnt != '0);

    // Timeout fires on the last WAIT cycle unless done arrives at the same time.
    assign w_timeout_hit = (r_state == ST_WAIT) && !w_done_ok && (r_wait_cnt == CNT_LAST);

    // Subtraction A-B is issued to the adder as A + (-B).
    assign w_b_eff = {bus.req_b[W-1] ^ bus.req_sub, bus.req_b[W-2:0]};

    // Gather the adder's individual status bits into the packed flag word.
    always_comb begin
        w_adder_flags            = '0;
        w_adder_flags[FLAG_NAN]  = bus.add_NAN;
        w_adder_flags[FLAG_OVF]  = bus.add_overflow;
        w_adder_flags[FLAG_UNF]  = bus.add_underflow;
        w_adder_flags[FLAG_ZERO] = bus.add_zero_flag;
    end

    // Marks the first clock after reset release; gates req_ready and enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)                    w_next_state = ST_LOAD;
            ST_LOAD:                                  w_next_state = ST_WAIT;
            ST_WAIT: if (w_done_ok || w_timeout_hit)  w_next_state = ST_RESP;
            ST_RESP: if (bus.rsp_ready)               w_next_state = ST_IDLE;
            default:                                  w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake readiness, load strobe and response valid.
    always_comb begin
        bus.req_ready = 1'b0;
        bus.add_load  = 1'b0;
        bus.rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE: bus.req_ready = r_active;
            ST_LOAD: bus.add_load  = 1'b1;
            ST_RESP: bus.rsp_valid = 1'b1;
            default: bus.req_ready = 1'b0;
        endcase
    end

    // Operand registers: loaded on the request handshake and held until the
    // next accepted request, so the adder sees stable inputs throughout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_add_a <= '0;
            r_add_b <= '0;
        end else if (w_accept) begin
            r_add_a <= bus.req_a;
            r_add_b <= w_b_eff;
        end
    end

    // WAIT-cycle counter: cleared in LOAD, counts up in WAIT, sticks at the
    // timeout value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_LOAD) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ST_WAIT) && (r_wait_cnt != CNT_LAST)) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    // Response capture: adder result and flags on done, zeros plus the
    // timeout marker when the adder never answers. Held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_result  <= '0;
            r_rsp_flags   <= '0;
            r_rsp_timeout <= 1'b0;
        end else if (w_done_ok) begin
            r_rsp_result  <= bus.add_result;
            r_rsp_flags   <= w_adder_flags;
            r_rsp_timeout <= 1'b0;
        end else if (w_timeout_hit) begin
            r_rsp_result  <= '0;
            r_rsp_flags   <= '0;
            r_rsp_timeout <= 1'b1;
        end
    end

    assign bus.add_enable  = r_active;
    assign bus.add_A       = r_add_a;
    assign bus.add_B       = r_add_b;
    assign bus.rsp_result  = r_rsp_result;
    assign bus.rsp_flags   = r_rsp_flags;
    assign bus.rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_fp_add_requester.sv
// Self-checking bench for fp_add_requester. A behavioural adder stub answers
// load strobes after a programmable latency (or always / never signals done);
// expected responses are pushed to a scoreboard queue when a request is
// driven and popped when the response appears.
module tb_fp_add_requester;
    import fp_pkg::*;

    localparam int MS = 23;
    localparam int ES = 8;
    localparam int W  = 32;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fp_add_requester_if #(.Mantissa_Size(MS), .Exponent_Size(ES)) bus ();

    fp_add_requester #(
        .Mantissa_Size(MS),
        .Exponent_Size(ES),
        .TIMEOUT(TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] result;
        logic [3:0]   flags;
        logic         timeout;
        int           lat;
        int           loads;
        logic [W-1:0] add_b;
        logic         rsp_gone;
    } txn_t;

    txn_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // ---------------- adder stub ----------------
    // mode 0: done rises lat cycles after load and stays high until next load
    // mode 1: done held high permanently (stale done)
    // mode 2: done never asserted
    int           stub_mode = 0;
    int           stub_lat  = 3;
    int           stub_cnt  = 0;
    logic         stub_done = 1'b0;
    logic [W-1:0] stub_a    = '0;
    logic [W-1:0] stub_b    = '0;
    logic [35:0]  stub_out;

    // Returns {NAN, OVF, UNF, ZERO, result} for an operand pair.
    function automatic logic [35:0] stub_compute(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == 32'h4000_0000 && b == 32'h4000_0000) return {4'b0000, 32'h4080_0000};
        if (a == 32'h7F00_0007 && b == 32'hFF00_0007) return {4'b0001, 32'h0000_0000};
        if (a == 32'h7F7F_FFFF && b == 32'h7F00_0001) return {4'b0100, 32'h7F80_0000};
        return {a[3:0] ^ b[7:4], a + b};
    endfunction

    always @(posedge clk) begin
        if (bus.add_load === 1'b1) begin
            stub_a    <= bus.add_A;
            stub_b    <= bus.add_B;
            stub_cnt  <= stub_lat;
            stub_done <= 1'b0;
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) stub_done <= 1'b1;
        end
    end

    assign stub_out          = stub_compute(stub_a, stub_b);
    assign bus.add_result    = stub_out[31:0];
    assign bus.add_NAN       = stub_out[32 + FLAG_NAN];
    assign bus.add_overflow  = stub_out[32 + FLAG_OVF];
    assign bus.add_underflow = stub_out[32 + FLAG_UNF];
    assign bus.add_zero_flag = stub_out[32 + FLAG_ZERO];
    assign bus.add_done      = (stub_mode == 1) ? 1'b1 :
                               (stub_mode == 0) ? stub_done : 1'b0;

    // Cycles from request handshake (edge 0) to first rsp_valid cycle.
    function automatic int exp_latency(input int mode, input int lat, output bit to);
        int c;
        to = 1'b0;
        if (mode == 1) return 4;
        if (mode == 2) begin
            to = 1'b1;
            return TO + 2;
        end
        // stub done is first visible in cycle lat+2; earliest usable is cycle 3
        c = (lat + 2 > 3) ? lat + 2 : 3;
        if (c <= TO + 1) return c + 1;
        to = 1'b1;
        return TO + 2;
    endfunction

    // Drives one request with rsp_ready high, records what the DUT produced.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input int mode, input int lat, output txn_t o);
        txn_t        e;
        logic [35:0] m;
        bit          to;
        int          guard;
        e.add_b    = {b[W-1] ^ sub, b[W-2:0]};
        e.lat      = exp_latency(mode, lat, to);
        m          = stub_compute(a, e.add_b);
        e.timeout  = to;
        e.result   = to ? '0 : m[31:0];
        e.flags    = to ? 4'h0 : m[35:32];
        e.loads    = 1;
        e.rsp_gone = 1'b1;
        sb_q.push_back(e);

        o.result   = 'x;
        o.flags    = 'x;
        o.timeout  = 1'bx;
        o.lat      = -1;
        o.loads    = 0;
        o.add_b    = 'x;
        o.rsp_gone = 1'b0;

        stub_mode     = mode;
        stub_lat      = lat;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_sub   = sub;
        bus.req_valid = 1'b1;
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (bus.req_ready !== 1'b1) begin
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        guard = 1;
        while (bus.rsp_valid !== 1'b1 && guard < 200) begin
            if (bus.add_load === 1'b1) o.loads++;
            @(posedge clk); #1; guard++;
        end
        if (bus.rsp_valid !== 1'b1) return;
        o.lat     = guard;
        o.result  = bus.rsp_result;
        o.flags   = bus.rsp_flags;
        o.timeout = bus.rsp_timeout;
        o.add_b   = bus.add_B;
        @(posedge clk); #1;
        o.rsp_gone = (bus.rsp_valid === 1'b0) && (bus.req_ready === 1'b1);
        $display("txn a=%h b=%h sub=%b mode=%0d lat=%0d -> result=%h flags=%b timeout=%b cycles=%0d",
                 a, b, sub, mode, lat, o.result, o.flags, o.timeout, o.lat);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [3*W+9-1:0] obs;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        obs = {bus.req_ready, bus.rsp_valid, bus.add_load, bus.add_enable, bus.rsp_timeout,
               bus.rsp_flags, bus.rsp_result, bus.add_A, bus.add_B};
        n_cmp++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, want 0", obs);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_ready_early: got %b, want 0", bus.req_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.add_enable !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: ready=%b enable=%b, want 1 1", bus.req_ready, bus.add_enable);
        end
        $display("txn reset released, req_ready=%b add_enable=%b", bus.req_ready, bus.add_enable);
    endtask

    task automatic test_normal_add;
        txn_t o, e;
        run_op(32'h4000_0000, 32'h4000_0000, 1'b0, 0, 2, o);
        e = sb_q.pop_front();
        n_cmp++; if (o.result !== e.result) begin n_err++; $display("FAIL add_result: got %h, want %h", o.result, e.result); end
        n_cmp++; if (o.flags !== e.flags) begin n_err++; $display("FAIL add_flags: got %b, want %b", o.flags, e.flags); end
        n_cmp++; if (o.timeout !== e.timeout) begin n_err++; $display("FAIL add_timeout: got %b, want %b", o.timeout, e.timeout); end
        n_cmp++; if (o.lat !== e.lat) begin n_err++; $display("FAIL add_latency: got %0d, want %0d", o.lat, e.lat); end
        n_cmp++; if (o.loads !== e.loads) begin n_err++; $display("FAIL add_load_count: got %0d, want %0d", o.loads, e.loads); end
        n_cmp++; if (o.rsp_gone !== e.rsp_gone) begin n_err++; $display("FAIL add_rsp_release: got %b, want %b", o.rsp_gone, e.rsp_gone); end
    endtask

    task automatic test_sub_zero;
        txn_t o, e;
        run_op(32'h7F00_0007, 32'h7F00_0007, 1'b1, 0, 1, o);
        e = sb_q.pop_front();
        n_cmp++; if (o.add_b !== 32'hFF00_0007) begin n_err++; $display("FAIL sub_add_B: got %h, want ff000007", o.add_b); end
        n_cmp++; if (o.result !== e.result) begin n_err++; $display("FAIL sub_result: got %h, want %h", o.result, e.result); end
        n_cmp++; if (o.flags !== e.flags) begin n_err++; $display("FAIL sub_flags: got %b, want %b", o.flags, e.flags); end
        n_cmp++; if (o.lat !== e.lat) begin n_err++; $display("FAIL sub_latency: got %0d, want %0d", o.lat, e.lat); end
    endtask

    task automatic test_overflow;
        txn_t o, e;
        run_op(32'h7F7F_FFFF, 32'h7F00_0001, 1'b0, 0, 5, o);
        e = sb_q.pop_front();
        n_cmp++; if (o.result !== e.result) begin n_err++; $display("FAIL ovf_result: got %h, want %h", o.result, e.result); end
        n_cmp++; if (o.flags !== e.flags) begin n_err++; $display("FAIL ovf_flags: got %b, want %b", o.flags, e.flags); end
        n_cmp++; if (o.lat !== e.lat) begin n_err++; $display("FAIL ovf_latency: got %0d, want %0d", o.lat, e.lat); end
    endtask

    task automatic test_stale_done;
        txn_t o, e;
        run_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 1, 0, o);
        e = sb_q.pop_front();
        n_cmp++; if (o.lat !== e.lat) begin n_err++; $display("FAIL stale_latency: got %0d, want %0d", o.lat, e.lat); end
        n_cmp++; if (o.result !== e.result) begin n_err++; $display("FAIL stale_result: got %h, want %h", o.result, e.result); end
        n_cmp++; if (o.timeout !== e.timeout) begin n_err++; $display("FAIL stale_timeout: got %b, want %b", o.timeout, e.timeout); end
    endtask

    task automatic test_timeout;
        txn_t o, e;
        run_op(32'h1234_5678, 32'h0BAD_F00D, 1'b0, 2, 0, o);
        e = sb_q.pop_front();
        n_cmp++; if (o.timeout !== e.timeout) begin n_err++; $display("FAIL to_flag: got %b, want %b", o.timeout, e.timeout); end
        n_cmp++; if (o.result !== e.result) begin n_err++; $display("FAIL to_result: got %h, want %h", o.result, e.result); end
        n_cmp++; if (o.flags !== e.flags) begin n_err++; $display("FAIL to_flags: got %b, want %b", o.flags, e.flags); end
        n_cmp++; if (o.lat !== e.lat) begin n_err++; $display("FAIL to_latency: got %0d, want %0d", o.lat, e.lat); end
    endtask

    // Done on the last WAIT cycle still wins; one cycle later it is too late.
    task automatic test_timeout_boundary;
        txn_t o, e;
        for (int k = 0; k < 2; k++) begin
            run_op(32'h4120_0000 + k, 32'h4040_0000, 1'b0, 0, TO - 1 + k, o);
            e = sb_q.pop_front();
            n_cmp++; if (o.timeout !== e.timeout) begin n_err++; $display("FAIL edge%0d_timeout: got %b, want %b", k, o.timeout, e.timeout); end
            n_cmp++; if (o.result !== e.result) begin n_err++; $display("FAIL edge%0d_result: got %h, want %h", k, o.result, e.result); end
            n_cmp++; if (o.lat !== e.lat) begin n_err++; $display("FAIL edge%0d_latency: got %0d, want %0d", k, o.lat, e.lat); end
        end
    endtask

    task automatic test_random_stream;
        txn_t o, e;
        logic [W-1:0] a, b;
        logic sub;
        for (int k = 0; k < 6; k++) begin
            a   = (k == 0) ? 32'h7FC0_0000 : $urandom;
            b   = (k == 1) ? 32'h7F80_0000 : $urandom;
            sub = 1'($urandom_range(0, 1));
            run_op(a, b, sub, 0, $urandom_range(1, 8), o);
            e = sb_q.pop_front();
            n_cmp++; if (o.add_b !== e.add_b) begin n_err++; $display("FAIL rnd%0d_add_B: got %h, want %h", k, o.add_b, e.add_b); end
            n_cmp++; if (o.result !== e.result) begin n_err++; $display("FAIL rnd%0d_result: got %h, want %h", k, o.result, e.result); end
            n_cmp++; if (o.flags !== e.flags) begin n_err++; $display("FAIL rnd%0d_flags: got %b, want %b", k, o.flags, e.flags); end
            n_cmp++; if (o.lat !== e.lat) begin n_err++; $display("FAIL rnd%0d_latency: got %0d, want %0d", k, o.lat, e.lat); end
            n_cmp++; if (o.loads !== e.loads) begin n_err++; $display("FAIL rnd%0d_loads: got %0d, want %0d", k, o.loads, e.loads); end
        end
    endtask

    task automatic test_backpressure;
        txn_t        e1, e2;
        logic [35:0] m;
        int          guard;
        logic [W-1:0] a1, b1, a2, b2;
        a1 = 32'h3F80_0000; b1 = 32'h4000_0000;
        a2 = 32'h4120_0000; b2 = 32'hC0A0_0000;
        m = stub_compute(a1, b1);
        e1.result = m[31:0]; e1.flags = m[35:32]; e1.timeout = 1'b0;
        e1.lat = 0; e1.loads = 1; e1.add_b = b1; e1.rsp_gone = 1'b1;
        sb_q.push_back(e1);
        m = stub_compute(a2, b2);
        e2.result = m[31:0]; e2.flags = m[35:32]; e2.timeout = 1'b0;
        e2.lat = 0; e2.loads = 1; e2.add_b = b2; e2.rsp_gone = 1'b1;
        sb_q.push_back(e2);

        stub_mode = 0; stub_lat = 3;
        bus.rsp_ready = 1'b0;
        bus.req_a = a1; bus.req_b = b1; bus.req_sub = 1'b0; bus.req_valid = 1'b1;
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        // second request presented immediately and held
        bus.req_a = a2; bus.req_b = b2;
        guard = 0;
        while (bus.rsp_valid !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
        e1 = sb_q.pop_front();
        n_cmp++;
        if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_first_rsp: rsp_valid=%b, want 1", bus.rsp_valid); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (bus.rsp_result !== e1.result || bus.rsp_flags !== e1.flags || bus.rsp_valid !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold%0d: got valid=%b %h/%b, want 1 %h/%b", i, bus.rsp_valid, bus.rsp_result, bus.rsp_flags, e1.result, e1.flags);
            end
            n_cmp++;
            if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL bp_req_ready%0d: got %b, want 0", i, bus.req_ready); end
            @(posedge clk); #1;
        end
        $display("txn bp first a=%h b=%h -> result=%h flags=%b", a1, b1, bus.rsp_result, bus.rsp_flags);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_after_rsp: ready=%b valid=%b, want 1 0", bus.req_ready, bus.rsp_valid);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n_cmp++;
        if (bus.add_load !== 1'b1 || bus.add_A !== a2) begin
            n_err++;
            $display("FAIL bp_second_accept: load=%b add_A=%h, want 1 %h", bus.add_load, bus.add_A, a2);
        end
        guard = 0;
        while (bus.rsp_valid !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
        e2 = sb_q.pop_front();
        n_cmp++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== e2.result || bus.rsp_flags !== e2.flags) begin
            n_err++;
            $display("FAIL bp_second_rsp: valid=%b %h/%b, want 1 %h/%b", bus.rsp_valid, bus.rsp_result, bus.rsp_flags, e2.result, e2.flags);
        end
        $display("txn bp second a=%h b=%h -> result=%h flags=%b", a2, b2, bus.rsp_result, bus.rsp_flags);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_wait;
        logic [3*W+9-1:0] obs;
        int guard;
        bit seen;
        stub_mode = 2;
        bus.req_a = 32'h4248_0000; bus.req_b = 32'h4120_0000; bus.req_sub = 1'b1; bus.req_valid = 1'b1;
        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n_cmp++;
        if (bus.add_load !== 1'b1) begin n_err++; $display("FAIL mid_load: got %b, want 1", bus.add_load); end
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        obs = {bus.req_ready, bus.rsp_valid, bus.add_load, bus.add_enable, bus.rsp_timeout,
               bus.rsp_flags, bus.rsp_result, bus.add_A, bus.add_B};
        n_cmp++;
        if (obs !== '0) begin n_err++; $display("FAIL mid_async_clear: got %h, want 0", obs); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready_after: got %b, want 1", bus.req_ready); end
        seen = 1'b0;
        for (int i = 0; i < TO + 10; i++) begin
            if (bus.rsp_valid !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL mid_no_rsp: rsp_valid pulse seen=%b, want 0", seen); end
        $display("txn reset mid-wait, dropped operation, req_ready=%b", bus.req_ready);
    endtask

    // Global bound in case a DUT fault stalls a loop beyond its own guard.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sub   = 1'b0;
        bus.rsp_ready = 1'b1;

        test_reset();
        test_normal_add();
        test_sub_zero();
        test_overflow();
        test_stale_done();
        test_timeout();
        test_timeout_boundary();
        test_random_stream();
        test_backpressure();
        test_reset_mid_wait();

        n_cmp++;
        if (sb_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_leftover: got %0d, want 0", sb_q.size()); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
